// File: rtl/mp_add_scheduler_pkg.sv
// mp_add_scheduler_pkg: FSM state enumeration and word width shared by the scheduler files
package mp_add_scheduler_pkg;
  localparam int WORD_W = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/mp_add_scheduler_ks.sv
// mp_add_scheduler_ks: 16-bit Kogge-Stone adder (A, B, Cin in; S, Cout out)
module mp_add_scheduler_ks (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Cout
);
  logic [15:0] w_g, w_p, w_gn, w_pn, w_p0, w_c;
  always_comb begin
    w_g = A & B;
    w_p = A ^ B;
    w_p0 = w_p;
    w_gn = w_g;
    w_pn = w_p;
    for (int l = 1; l < 16; l = l * 2) begin
      w_gn = w_g;
      w_pn = w_p;
      for (int i = l; i < 16; i++) begin
        w_gn[i] = w_g[i] | (w_p[i] & w_g[i-l]);
        w_pn[i] = w_p[i] & w_p[i-l];
      end
      w_g = w_gn;
      w_p = w_pn;
    end
    w_c = w_g | (w_p & {16{Cin}});
  end
  assign S = w_p0 ^ {w_c[14:0], Cin};
  assign Cout = w_c[15];
endmodule

// File: rtl/mp_add_scheduler.sv
// mp_add_scheduler: two-requester round-robin multi-word adder (req_* in, out_* result) using one 16-bit adder per cycle
module mp_add_scheduler
  import mp_add_scheduler_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [WORD_W*WORDS-1:0]   req_a0,
  input  logic [WORD_W*WORDS-1:0]   req_b0,
  input  logic [WORD_W*WORDS-1:0]   req_a1,
  input  logic [WORD_W*WORDS-1:0]   req_b1,
  input  logic [1:0]                req_cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORD_W*WORDS-1:0]   out_sum,
  output logic                      out_cout,
  output logic                      out_id
);
  localparam int KW = WORDS > 1 ? $clog2(WORDS) : 1;
  state_t r_state, w_next;
  logic [KW-1:0] r_k;
  logic r_rr, r_carry, r_cin, r_id, r_cout, r_oid;
  logic [WORDS-1:0][WORD_W-1:0] r_a, r_b, r_res, r_sum, w_res;
  logic [1:0] w_gnt;
  logic w_acc, w_sel, w_last, w_ci, w_co;
  logic [WORD_W-1:0] w_s;
  assign w_gnt = &req_valid ? (r_rr ? 2'b10 : 2'b01) : req_valid;
  assign w_acc = |(req_valid & req_ready);
  assign w_sel = req_ready[1];
  assign w_last = r_k == KW'(WORDS - 1);
  assign w_ci = r_k == '0 ? r_cin : r_carry;
  mp_add_scheduler_ks u_add (.A(r_a[r_k]), .B(r_b[r_k]), .Cin(w_ci), .S(w_s), .Cout(w_co));
  always_comb begin
    w_res = r_res;
    w_res[r_k] = w_s;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == IDLE ? (w_acc ? RUN : IDLE) :
             r_state == RUN  ? (w_last ? DONE : RUN) :
             (out_ready ? IDLE : DONE);
  always_comb begin
    req_ready = (r_state == IDLE && !rst) ? w_gnt : 2'b00;
    out_valid = r_state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {r_k, r_rr, r_carry, r_cin, r_id, r_cout, r_oid} <= '0;
      {r_a, r_b, r_res, r_sum} <= '0;
    end else if (w_acc) begin
      r_a <= w_sel ? req_a1 : req_a0;
      r_b <= w_sel ? req_b1 : req_b0;
      r_cin <= req_cin[w_sel];
      r_id <= w_sel;
      r_rr <= ~w_sel;
      r_k <= '0;
    end else if (r_state == RUN) begin
      r_res <= w_res;
      r_carry <= w_co;
      r_k <= r_k + 1'b1;
      if (w_last) begin
        r_sum <= w_res;
        r_cout <= w_co;
        r_oid <= r_id;
      end
    end
  assign out_sum = r_sum;
  assign out_cout = r_cout;
  assign out_id = r_oid;
endmodule
